// File: rtl/cra_pipe_if.sv
// Streaming operand/result bundle for the pipelined carry-ripple adder.
// The slave side is the adder; the master side is whoever feeds operands and drains results.
interface cra_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             VALID_in;
  logic             READY_out;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             C_in;
  logic             SUB_in;
  logic             VALID_out;
  logic             READY_in;
  logic [WIDTH-1:0] S_out;
  logic             C_out;
  logic             OVF_out;

  modport slave (
    input  VALID_in,
    input  A_in,
    input  B_in,
    input  C_in,
    input  SUB_in,
    input  READY_in,
    output READY_out,
    output VALID_out,
    output S_out,
    output C_out,
    output OVF_out
  );

  modport master (
    output VALID_in,
    output A_in,
    output B_in,
    output C_in,
    output SUB_in,
    output READY_in,
    input  READY_out,
    input  VALID_out,
    input  S_out,
    input  C_out,
    input  OVF_out
  );
endinterface

// File: rtl/cra_pipe.sv
// Pipelined carry-ripple adder/subtractor. The operands are cut into STAGES equal chunks; each
// stage ripples one chunk and registers its carry-out for the next stage. Full operands travel
// with the beat so later stages find their chunk, and finished sum chunks accumulate so the
// complete result lines up in the last stage register, which drives the outputs directly.
// The interface width parameter must equal WIDTH.
module cra_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic         CLK_in,
  input logic         RSTn_in,
  cra_pipe_if.slave   bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("cra_pipe: WIDTH must be a non-zero multiple of STAGES and STAGES <= WIDTH");
  end

  // Stage registers: index k holds a beat whose chunks 0..k are done.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic             ovf_q;
  logic             adv;

  // Whole pipe moves together whenever the output slot is free or being drained.
  always_comb begin
    adv           = bus.READY_in | ~vld_q[STAGES-1];
    bus.READY_out = adv;
    bus.VALID_out = vld_q[STAGES-1];
    bus.S_out     = sum_q[STAGES-1];
    bus.C_out     = cy_q[STAGES-1];
    bus.OVF_out   = ovf_q;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] s_new;

    if (k == 0) begin : g_first
      // Stage 0 takes operands straight from the port; subtraction inverts B here only.
      always_comb begin
        a_src = bus.A_in;
        b_src = bus.SUB_in ? ~bus.B_in : bus.B_in;
        s_src = '0;
        c_src = bus.C_in;
        v_src = bus.VALID_in;
      end
    end else begin : g_next
      // Later stages continue the beat held in the previous stage register.
      always_comb begin
        a_src = a_q[k-1];
        b_src = b_q[k-1];
        s_src = sum_q[k-1];
        c_src = cy_q[k-1];
        v_src = vld_q[k-1];
      end
    end

    // Ripple this stage's chunk and merge it into the partially built sum.
    always_comb begin
      part  = {1'b0, a_src[k*CHUNK +: CHUNK]} + {1'b0, b_src[k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_src};
      s_new = s_src;
      s_new[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    // Stage register; data only loads with a valid beat so bubbles never disturb held values.
    always_ff @(posedge CLK_in) begin
      if (!RSTn_in) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end else if (adv) begin
        vld_q[k] <= v_src;
        if (v_src) begin
          a_q[k]   <= a_src;
          b_q[k]   <= b_src;
          sum_q[k] <= s_new;
          cy_q[k]  <= part[CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic msb_cin;

      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      always_comb begin
        msb_cin = part[CHUNK-1] ^ a_src[WIDTH-1] ^ b_src[WIDTH-1];
      end

      // Overflow flag registered alongside the final chunk.
      always_ff @(posedge CLK_in) begin
        if (!RSTn_in) begin
          ovf_q <= 1'b0;
        end else if (adv && v_src) begin
          ovf_q <= msb_cin ^ part[CHUNK];
        end
      end
    end
  end

endmodule

// File: tb/tb_cra_pipe.sv
// Self-checking bench for cra_pipe: three instances (4, 1 and 32 stages) fed the same beats,
// each with its own expected-result queue checked whenever a result transfers out.
module tb_cra_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q32[$];
  int   st4[$];
  int   st1[$];
  int   st32[$];

  cra_pipe_if #(.WIDTH(32)) io4 ();
  cra_pipe_if #(.WIDTH(32)) io1 ();
  cra_pipe_if #(.WIDTH(32)) io32 ();

  cra_pipe #(.WIDTH(32), .STAGES(4))  u_dut4  (.CLK_in(clk), .RSTn_in(rst_n), .bus(io4));
  cra_pipe #(.WIDTH(32), .STAGES(1))  u_dut1  (.CLK_in(clk), .RSTn_in(rst_n), .bus(io1));
  cra_pipe #(.WIDTH(32), .STAGES(32)) u_dut32 (.CLK_in(clk), .RSTn_in(rst_n), .bus(io32));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c,
                                 input logic sub);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] full;
    be    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {32'd0, c};
    e.s   = full[31:0];
    e.c   = full[32];
    e.ovf = (a[31] == be[31]) && (full[31] != a[31]);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic sub);
    io4.VALID_in = v;  io4.A_in = a;  io4.B_in = b;  io4.C_in = c;  io4.SUB_in = sub;
    io1.VALID_in = v;  io1.A_in = a;  io1.B_in = b;  io1.C_in = c;  io1.SUB_in = sub;
    io32.VALID_in = v; io32.A_in = a; io32.B_in = b; io32.C_in = c; io32.SUB_in = sub;
  endtask

  task automatic set_ready(input logic r);
    io4.READY_in = r;
    io1.READY_in = r;
    io32.READY_in = r;
  endtask

  // Present one beat until every instance accepts it; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub,
                      input exp_t e);
    int guard = 0;
    drive(1'b1, a, b, c, sub);
    while (!(io4.READY_out && io1.READY_out && io32.READY_out) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_in_time", 64'(guard < 100), 64'd1);
    q4.push_back(e);
    q1.push_back(e);
    q32.push_back(e);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic send_rand();
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        sub;
    a   = $urandom;
    b   = $urandom;
    c   = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    send(a, b, c, sub, model(a, b, c, sub));
  endtask

  task automatic drain();
    int guard = 0;
    while ((q4.size() + q1.size() + q32.size()) != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_all", 64'(q4.size() + q1.size() + q32.size()), 64'd0);
  endtask

  // Scoreboard monitors: a result transfers on the next rising edge when valid and ready.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && io4.VALID_out && io4.READY_in) begin
      chk("s4_expected_beat", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("s4_sum", 64'(io4.S_out), 64'(e.s));
        chk("s4_cout", 64'(io4.C_out), 64'(e.c));
        chk("s4_ovf", 64'(io4.OVF_out), 64'(e.ovf));
        st4.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && io1.VALID_out && io1.READY_in) begin
      chk("s1_expected_beat", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("s1_sum", 64'(io1.S_out), 64'(e.s));
        chk("s1_cout", 64'(io1.C_out), 64'(e.c));
        chk("s1_ovf", 64'(io1.OVF_out), 64'(e.ovf));
        st1.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && io32.VALID_out && io32.READY_in) begin
      chk("s32_expected_beat", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("s32_sum", 64'(io32.S_out), 64'(e.s));
        chk("s32_cout", 64'(io32.C_out), 64'(e.c));
        chk("s32_ovf", 64'(io32.OVF_out), 64'(e.ovf));
        st32.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int l1;
    int l4;
    int l32;
    int seen;

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_ready(1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid4", 64'(io4.VALID_out), 64'd0);
    chk("rst_valid1", 64'(io1.VALID_out), 64'd0);
    chk("rst_valid32", 64'(io32.VALID_out), 64'd0);
    chk("rst_sum4", 64'(io4.S_out), 64'd0);
    chk("rst_cout4", 64'(io4.C_out), 64'd0);
    chk("rst_ovf4", 64'(io4.OVF_out), 64'd0);
    chk("rst_ready4", 64'(io4.READY_out), 64'd1);

    // Add wrap with latency measured on every depth
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{s: 32'h0, c: 1'b1, ovf: 1'b0});
    n = 1; l1 = 0; l4 = 0; l32 = 0;
    while ((l1 == 0 || l4 == 0 || l32 == 0) && n < 40) begin
      if (l1 == 0 && io1.VALID_out) l1 = n;
      if (l4 == 0 && io4.VALID_out) l4 = n;
      if (l32 == 0 && io32.VALID_out) l32 = n;
      @(posedge clk); #1;
      n++;
    end
    chk("latency1", 64'(l1), 64'd1);
    chk("latency4", 64'(l4), 64'd4);
    chk("latency32", 64'(l32), 64'd32);
    drain();

    // Subtraction and signed overflow corners, back-to-back
    send(32'd5, 32'd7, 1'b1, 1'b1, '{s: 32'hFFFF_FFFE, c: 1'b0, ovf: 1'b0});
    send(32'd7, 32'd5, 1'b1, 1'b1, '{s: 32'h0000_0002, c: 1'b1, ovf: 1'b0});
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, '{s: 32'h8000_0000, c: 1'b0, ovf: 1'b1});
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{s: 32'h0, c: 1'b1, ovf: 1'b1});
    drain();

    // Full-rate stream of random beats
    st4.delete(); st1.delete(); st32.delete();
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    chk("stream_count4", 64'(st4.size()), 64'd16);
    chk("stream_count1", 64'(st1.size()), 64'd16);
    chk("stream_count32", 64'(st32.size()), 64'd16);
    if (st4.size() == 16) chk("stream_span4", 64'(st4[15] - st4[0]), 64'd15);
    if (st1.size() == 16) chk("stream_span1", 64'(st1[15] - st1[0]), 64'd15);
    if (st32.size() == 16) chk("stream_span32", 64'(st32[15] - st32[0]), 64'd15);

    // Backpressure with the 4-stage pipe full
    for (int i = 0; i < 6; i++) send_rand();
    set_ready(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid4", 64'(io4.VALID_out), 64'd1);
      chk("bp_ready4", 64'(io4.READY_out), 64'd0);
      if (q4.size() != 0) begin
        chk("bp_sum4", 64'(io4.S_out), 64'(q4[0].s));
        chk("bp_cout4", 64'(io4.C_out), 64'(q4[0].c));
      end
    end
    chk("bp_pending4", 64'(q4.size()), 64'd4);
    set_ready(1'b1);
    drain();

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) send_rand();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid4", 64'(io4.VALID_out), 64'd0);
    chk("mid_rst_valid1", 64'(io1.VALID_out), 64'd0);
    chk("mid_rst_valid32", 64'(io32.VALID_out), 64'd0);
    chk("mid_rst_sum4", 64'(io4.S_out), 64'd0);
    chk("mid_rst_sum1", 64'(io1.S_out), 64'd0);
    q4.delete(); q1.delete(); q32.delete();
    rst_n = 1'b1;
    chk("post_rst_ready4", 64'(io4.READY_out), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (io4.VALID_out || io1.VALID_out || io32.VALID_out) seen++;
      @(posedge clk); #1;
    end
    chk("no_stale_beat", 64'(seen), 64'd0);

    // Pipe still works after the flush
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{s: 32'h2345_678A, c: 1'b0, ovf: 1'b0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
